// File: rtl/rbs_pkg.sv
// rbs_pkg: shared widths and stage-register layout for the pipelined subtractor
//   RBS_WIDTH/RBS_SLICE are the default operand width and bits per stage.
//   stage_t holds what one pipeline stage hands to the next.
package rbs_pkg;
  localparam int RBS_WIDTH = 16;
  localparam int RBS_SLICE = 4;
  localparam int RBS_STAGES = RBS_WIDTH / RBS_SLICE;
  typedef struct packed {
    logic valid;
    logic borrow;
    logic a_msb;
    logic b_msb;
    logic [RBS_WIDTH-1:0] res;
    logic [RBS_WIDTH-1:0] a_rem;
    logic [RBS_WIDTH-1:0] b_rem;
  } stage_t;
endpackage

// File: rtl/rbs_sub_pipe_if.sv
// rbs_sub_pipe_if: valid/ready operand and result bus of the pipelined subtractor
//   operand side: in_valid, in_ready, a, b
//   result side:  out_valid, out_ready, res, borrow_out, ovf
//   slave = subtractor, master = producer/consumer
interface rbs_sub_pipe_if import rbs_pkg::*; #(parameter int WIDTH = RBS_WIDTH);
  logic in_valid, in_ready, out_valid, out_ready, borrow_out, ovf;
  logic [WIDTH-1:0] a, b, res;
  modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, res, borrow_out, ovf);
  modport slave (input in_valid, a, b, out_ready, output in_ready, out_valid, res, borrow_out, ovf);
endinterface

// File: rtl/rbs_slice.sv
// rbs_slice: combinational SLICE-bit ripple-borrow subtractor d = a - b - bin
//   in: a, b (SLICE bits), bin   out: d (SLICE bits), bout
module rbs_slice import rbs_pkg::*; #(parameter int SLICE = RBS_SLICE) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] d,
  output logic             bout
);
  logic [SLICE:1] br;
  logic h_d, h_b;
  // bit 0: half-subtractor, then the incoming borrow folded in
  assign h_d = a[0] ^ b[0];
  assign h_b = ~a[0] & b[0];
  assign d[0] = h_d ^ bin;
  assign br[1] = h_b | (~h_d & bin);
  genvar i;
  for (i = 1; i < SLICE; i++) begin : g_fs
    assign d[i] = a[i] ^ b[i] ^ br[i];
    assign br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
  end
  assign bout = br[SLICE];
endmodule

// File: rtl/rbs_sub_pipe.sv
// rbs_sub_pipe: pipelined ripple-borrow subtractor res = a - b, one SLICE per stage
//   clk, rst (async, active-high); bus: rbs_sub_pipe_if.slave
//   RBS_SUB_SAT_EN: when defined, res clamps to 0 on borrow (unsigned saturating)
module rbs_sub_pipe import rbs_pkg::*; #(
  parameter int WIDTH = RBS_WIDTH,
  parameter int SLICE = RBS_SLICE
) (
  input logic clk,
  input logic rst,
  rbs_sub_pipe_if.slave bus
);
  localparam int STAGES = WIDTH / SLICE;
  logic adv, unused_rem;
  stage_t last;
  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stage
    stage_t pr, q;
    logic [SLICE-1:0] d;
    logic bo;
    if (k == 0) begin : g_in
      always_comb begin
        pr = '0;
        pr.valid = bus.in_valid;
        pr.a_msb = bus.a[WIDTH-1];
        pr.b_msb = bus.b[WIDTH-1];
        pr.a_rem = bus.a;
        pr.b_rem = bus.b;
      end
    end else begin : g_link
      assign pr = g_stage[k-1].q;
    end
    rbs_slice #(.SLICE(SLICE)) u_slice (
      .a(pr.a_rem[SLICE-1:0]),
      .b(pr.b_rem[SLICE-1:0]),
      .bin(pr.borrow),
      .d(d),
      .bout(bo)
    );
    // operands shift down so every stage works on the low slice
    always_ff @(posedge clk or posedge rst)
      if (rst) q <= '0;
      else if (adv) begin
        q <= pr;
        q.res[k*SLICE +: SLICE] <= d;
        q.borrow <= bo;
        q.a_rem <= pr.a_rem >> SLICE;
        q.b_rem <= pr.b_rem >> SLICE;
      end
  end
  assign last = g_stage[STAGES-1].q;
  // the last slice has consumed every operand bit, so these are always zero
  assign unused_rem = ^{last.a_rem, last.b_rem};
  assign adv = !last.valid | bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = last.valid;
  assign bus.borrow_out = last.borrow;
  assign bus.ovf = (last.a_msb ^ last.b_msb) & (last.res[WIDTH-1] ^ last.a_msb);
`ifdef RBS_SUB_SAT_EN
  assign bus.res = last.borrow ? '0 : last.res;
`else
  assign bus.res = last.res;
`endif
endmodule
